butterfly_pipe: RTL and testbench
=================================

// Module: butterfly_pipe
// PURPOSE
//  Next-generation radix-2 complex butterfly for the FFT core of the MFCC frame_fft_block.
//  Fixed 3-stage pipeline with valid/ready backpressure and per-beat DIT/DIF mode select.
//  Optional per-stage divide-by-2 scaling, round-half-up and saturation with an overflow flag.
//  Carries a user tag so the FFT controller can track bin addresses through the pipe.
// PARAMETERS
//  DATA_W   16  signed width of a, b, y0, y1 components
//  TW_W     16  signed width of twiddle components
//  TW_FRAC  15  fractional bits of twiddle (Q1.TW_FRAC)
//  TAG_W    8   width of pass-through tag
// PORTS
//  clk        in   1        clock, rising edge
//  reset_n    in   1        asynchronous reset, active low
//  in_valid   in   1        input beat valid
//  in_ready   out  1        block can accept the beat this cycle
//  in_dif     in   1        0: DIT beat, 1: DIF beat
//  in_scale   in   1        1: divide results by 2 (rounded)
//  in_tag     in   TAG_W    user tag, returned unchanged with the result
//  a_re/a_im  in   DATA_W   operand a
//  b_re/b_im  in   DATA_W   operand b
//  w_re/w_im  in   TW_W     twiddle W
//  out_valid  out  1        output beat valid
//  out_ready  in   1        downstream accepts the beat
//  y0_re/y0_im out DATA_W   first result
//  y1_re/y1_im out DATA_W   second result
//  out_tag    out  TAG_W    tag of this result
//  out_ovf    out  1        saturation occurred on any component of this beat
// BEHAVIOUR
//  - Math: rnd(x,k) = (x + 2^(k-1)) >>> k for k>0, and x for k=0. sat() clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//    Intermediates are kept at full width with no wrap before sat.
//  - DIT: bw = rnd(b*W, TW_FRAC) (complex product, unsaturated).
//    y0 = sat(rnd(a+bw, s)) and y1 = sat(rnd(a-bw, s)), where s = in_scale.
//  - DIF: y0 = sat(rnd(a+b, s)) and y1 = sat(rnd((a-b)*W, TW_FRAC+s)).
//  - out_ovf = OR of the clamp events on all 4 components of the beat.
//  - Stages:
//    S1 registers operands and mode, and forms a+b and a-b.
//    S2 registers the 4 partial products.
//    S3 combines, rounds, saturates and drives the outputs.
//  - Each stage holds a valid bit. A stage loads when it is empty or when its content moves on this cycle.
//  - Stage 3 moves on when out_ready=1. in_ready = !v1 | (v1 & stage-2 accepts); this is a combinational chain from out_ready.
//  - A beat transfers when in_valid & in_ready. Latency is 3 cycles from transfer to out_valid when out_ready is held high.
//  - Throughput is 1 beat per cycle. Bubbles collapse: an empty stage is refilled even while out_ready=0.
//  - Up to 3 beats are held when out_ready=0; in_ready drops only when all 3 stages are valid.
//  - While out_valid=1 & out_ready=0, every output stays stable.
//  - Mode, scale and tag travel with the beat. Changing them between beats takes effect per beat, with no flush.
//  - Simultaneous output pop and input push at full occupancy: the input beat is accepted in the same cycle.
//  - Reset, at any time including mid-operation: all valid bits clear and in-flight beats are dropped.
//    out_valid=0, all y*, out_tag and out_ovf = 0. in_ready=1 on the first cycle after reset_n rises.
//  - Inputs are ignored when in_valid=0. The data registers hold their contents and do not toggle.
// TESTING
//  1. DIT, s=0: a=1000+0j, b=2000+0j, W=32767+0j -> y0=3000+0j, y1=-1000+0j, ovf=0, 3 cycles later.
//  2. DIT, s=0: a=1000, b=2000, W=0-32768j -> y0=1000-2000j, y1=1000+2000j.
//     DIF with the same operands -> y0=3000+0j, y1=0+1000j.
//  3. Saturation: a=b=32767+0j, W=32767 -> s=0 gives y0=32767, y1=1, ovf=1.
//     s=1 gives y0=32767, y1=1, ovf=0.
//  4. Backpressure: stream 10 tagged beats (tag 0..9) with out_ready toggling pseudo-randomly.
//     -> In-order results, no loss or duplication, in_ready=0 only with 3 beats held, stable outputs while stalled.
//  5. Full-rate mixed stream: alternate DIT/DIF and scale every beat with out_ready=1 -> each result matches the golden model.
//  6. Assert reset_n low with 2 beats in flight.
//     -> out_valid=0 and outputs 0 immediately; no stale beat emerges after release; the first new beat has latency 3.

Source files
------------

// File: rtl/butterfly_pipe.sv
// Radix-2 complex butterfly (DIT/DIF per beat), 3-stage valid/ready pipeline
// with optional divide-by-2, round-half-up, saturation and a pass-through tag.
module butterfly_pipe #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TW_W    = 16,
    parameter int unsigned TW_FRAC = 15,
    parameter int unsigned TAG_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_dif,
    input  logic                     in_scale,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    input  logic signed [TW_W-1:0]   w_re,
    input  logic signed [TW_W-1:0]   w_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] y0_re,
    output logic signed [DATA_W-1:0] y0_im,
    output logic signed [DATA_W-1:0] y1_re,
    output logic signed [DATA_W-1:0] y1_im,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_ovf
);

    localparam int unsigned XW = DATA_W + 1;
    localparam int unsigned IW = DATA_W + TW_W + 3;
    localparam logic signed [IW-1:0] SAT_MAX = (IW'(1) <<< (DATA_W - 1)) - IW'(1);
    localparam logic signed [IW-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic signed [IW-1:0] rnd(input logic signed [IW-1:0] x,
                                                 input int unsigned k);
        logic signed [IW-1:0] half;
        if (k == 0) return x;
        half = IW'(1) <<< (k - 1);
        return (x + half) >>> k;
    endfunction

    // {clamped, value}
    function automatic logic [DATA_W:0] sat(input logic signed [IW-1:0] x);
        if (x > SAT_MAX) return {1'b1, DATA_W'(SAT_MAX)};
        if (x < SAT_MIN) return {1'b1, DATA_W'(SAT_MIN)};
        return {1'b0, DATA_W'(x)};
    endfunction

    // One real/imag lane: p is a (DIT) or a+b (DIF); prod is the unrounded twiddle product
    function automatic logic [2*DATA_W+1:0] lane(input logic signed [IW-1:0] p,
                                                 input logic signed [IW-1:0] prod,
                                                 input logic dif,
                                                 input logic scale);
        logic signed [IW-1:0] bw;
        logic signed [IW-1:0] t0;
        logic signed [IW-1:0] t1;
        int unsigned s;
        s  = {31'b0, scale};
        bw = rnd(prod, TW_FRAC);
        if (dif) begin
            t0 = rnd(p, s);
            t1 = rnd(prod, TW_FRAC + s);
        end else begin
            t0 = rnd(p + bw, s);
            t1 = rnd(p - bw, s);
        end
        return {sat(t0), sat(t1)};
    endfunction

    logic v1, v2;
    logic ld1, ld2, ld3;

    // A stage loads when empty or when its content moves on this cycle
    assign ld3      = !out_valid | out_ready;
    assign ld2      = !v2 | ld3;
    assign ld1      = !v1 | ld2;
    assign in_ready = ld1;

    logic                     s1_dif, s1_scale;
    logic [TAG_W-1:0]         s1_tag;
    logic signed [DATA_W-1:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im;
    logic signed [XW-1:0]     s1_sum_re, s1_sum_im, s1_dif_re, s1_dif_im;
    logic signed [TW_W-1:0]   s1_w_re, s1_w_im;

    // Stage 1: operand capture, a+b and a-b
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1        <= 1'b0;
            s1_dif    <= 1'b0;
            s1_scale  <= 1'b0;
            s1_tag    <= '0;
            s1_a_re   <= '0;
            s1_a_im   <= '0;
            s1_b_re   <= '0;
            s1_b_im   <= '0;
            s1_sum_re <= '0;
            s1_sum_im <= '0;
            s1_dif_re <= '0;
            s1_dif_im <= '0;
            s1_w_re   <= '0;
            s1_w_im   <= '0;
        end else begin
            if (ld1) v1 <= in_valid;
            if (ld1 && in_valid) begin
                s1_dif    <= in_dif;
                s1_scale  <= in_scale;
                s1_tag    <= in_tag;
                s1_a_re   <= a_re;
                s1_a_im   <= a_im;
                s1_b_re   <= b_re;
                s1_b_im   <= b_im;
                s1_sum_re <= XW'(a_re) + XW'(b_re);
                s1_sum_im <= XW'(a_im) + XW'(b_im);
                s1_dif_re <= XW'(a_re) - XW'(b_re);
                s1_dif_im <= XW'(a_im) - XW'(b_im);
                s1_w_re   <= w_re;
                s1_w_im   <= w_im;
            end
        end
    end

    logic signed [XW-1:0] x_re, x_im;
    assign x_re = s1_dif ? s1_dif_re : XW'(s1_b_re);
    assign x_im = s1_dif ? s1_dif_im : XW'(s1_b_im);

    logic                 s2_dif, s2_scale;
    logic [TAG_W-1:0]     s2_tag;
    logic signed [XW-1:0] s2_p_re, s2_p_im;
    logic signed [IW-1:0] s2_rr, s2_ii, s2_ri, s2_ir;

    // Stage 2: four partial products of (b or a-b) x W
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2       <= 1'b0;
            s2_dif   <= 1'b0;
            s2_scale <= 1'b0;
            s2_tag   <= '0;
            s2_p_re  <= '0;
            s2_p_im  <= '0;
            s2_rr    <= '0;
            s2_ii    <= '0;
            s2_ri    <= '0;
            s2_ir    <= '0;
        end else begin
            if (ld2) v2 <= v1;
            if (ld2 && v1) begin
                s2_dif   <= s1_dif;
                s2_scale <= s1_scale;
                s2_tag   <= s1_tag;
                s2_p_re  <= s1_dif ? s1_sum_re : XW'(s1_a_re);
                s2_p_im  <= s1_dif ? s1_sum_im : XW'(s1_a_im);
                s2_rr    <= IW'(x_re) * IW'(s1_w_re);
                s2_ii    <= IW'(x_im) * IW'(s1_w_im);
                s2_ri    <= IW'(x_re) * IW'(s1_w_im);
                s2_ir    <= IW'(x_im) * IW'(s1_w_re);
            end
        end
    end

    logic [2*DATA_W+1:0] lane_re, lane_im;
    always_comb begin
        lane_re = lane(IW'(s2_p_re), s2_rr - s2_ii, s2_dif, s2_scale);
        lane_im = lane(IW'(s2_p_im), s2_ri + s2_ir, s2_dif, s2_scale);
    end

    // Stage 3: round, saturate and hold the result until accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            y0_re     <= '0;
            y0_im     <= '0;
            y1_re     <= '0;
            y1_im     <= '0;
            out_tag   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (ld3) out_valid <= v2;
            if (ld3 && v2) begin
                y0_re   <= lane_re[2*DATA_W:DATA_W+1];
                y1_re   <= lane_re[DATA_W-1:0];
                y0_im   <= lane_im[2*DATA_W:DATA_W+1];
                y1_im   <= lane_im[DATA_W-1:0];
                out_tag <= s2_tag;
                out_ovf <= lane_re[2*DATA_W+1] | lane_re[DATA_W] |
                           lane_im[2*DATA_W+1] | lane_im[DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Scoreboard bench for butterfly_pipe: directed beats push expected results,
// an independent monitor pops and compares on every output transfer.
module tb_butterfly_pipe;

    localparam int unsigned DW   = 16;
    localparam int unsigned TAGW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic in_valid = 1'b0, in_ready, in_dif = 1'b0, in_scale = 1'b0;
    logic [TAGW-1:0] in_tag = '0;
    logic signed [DW-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0, w_re = '0, w_im = '0;
    logic out_valid, out_ready = 1'b1;
    logic signed [DW-1:0] y0_re, y0_im, y1_re, y1_im;
    logic [TAGW-1:0] out_tag;
    logic out_ovf;

    butterfly_pipe #(.DATA_W(16), .TW_W(16), .TW_FRAC(15), .TAG_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_dif(in_dif), .in_scale(in_scale),
        .in_tag(in_tag), .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .w_re(w_re), .w_im(w_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im),
        .out_tag(out_tag), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] y;
        logic [7:0]  tag;
        logic        ovf;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int chk_cnt = 0;
    int pass_cnt = 0;
    int cyc = 0;
    int bp_mode = 0;   // 0: ready high, 1: random, 2: ready low
    bit rdy_chk = 0;
    bit prev_stall = 0;
    logic [79:0] snap;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: ready rule, stall stability, in-order result comparison
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            prev_stall = 0;
        end else begin
            if (rdy_chk)
                check("in_ready vs occupancy", 80'(in_ready), 80'((sb.size() < 3) || out_ready));
            if (prev_stall)
                check("stable while stalled", {y0_re, y0_im, y1_re, y1_im, out_tag, 7'b0, out_ovf}, snap);
            if (out_valid && sb.size() == 0)
                check("spurious out_valid", 80'(out_valid), 80'(0));
            else if (out_valid && out_ready) begin
                e = sb.pop_front();
                check($sformatf("y tag%0d", e.tag), 80'({y0_re, y0_im, y1_re, y1_im}), 80'(e.y));
                check("tag", 80'(out_tag), 80'(e.tag));
                check($sformatf("ovf tag%0d", e.tag), 80'(out_ovf), 80'(e.ovf));
                if (e.lat) check($sformatf("latency tag%0d", e.tag), 80'(cyc - e.acc), 80'(3));
            end
            prev_stall = out_valid && !out_ready;
            snap = {y0_re, y0_im, y1_re, y1_im, out_tag, 7'b0, out_ovf};
        end
    end

    task automatic send(input bit dif, input bit scale, input int tag,
                        input int ar, input int ai, input int br, input int bi,
                        input int wr, input int wi,
                        input int e0r, input int e0i, input int e1r, input int e1i,
                        input bit ovf, input bit lat);
        exp_t e;
        int n;
        bit ok;
        in_valid = 1'b1; in_dif = dif; in_scale = scale; in_tag = 8'(tag);
        a_re = 16'(ar); a_im = 16'(ai); b_re = 16'(br); b_im = 16'(bi);
        w_re = 16'(wr); w_im = 16'(wi);
        n = 0; ok = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            n++;
        end
        if (!ok) begin
            check("accept timeout", 80'(in_ready), 80'(1));
            in_valid = 1'b0;
            return;
        end
        e.y = {16'(e0r), 16'(e0i), 16'(e1r), 16'(e1i)};
        e.tag = 8'(tag); e.ovf = ovf; e.acc = cyc; e.lat = lat;
        @(posedge clk); #1;
        sb.push_back(e);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain timeout", 80'(sb.size()), 80'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 80'(out_valid), 80'(0));
        check("reset outputs", {y0_re, y0_im, y1_re, y1_im, out_tag, 7'b0, out_ovf}, 80'(0));
        reset_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset", 80'(in_ready), 80'(1));
        @(posedge clk); #1;

        // Basic DIT/DIF vectors
        send(0, 0, 1, 1000, 0, 2000, 0, 32767, 0,      3000, 0, -1000, 0,     0, 1);
        send(0, 0, 2, 1000, 0, 2000, 0, 0, -32768,     1000, -2000, 1000, 2000, 0, 1);
        send(1, 0, 3, 1000, 0, 2000, 0, 0, -32768,     3000, 0, 0, 1000,      0, 1);
        // Saturation with and without scaling
        send(0, 0, 4, 32767, 0, 32767, 0, 32767, 0,    32767, 0, 1, 0,        1, 1);
        send(0, 1, 5, 32767, 0, 32767, 0, 32767, 0,    32767, 0, 1, 0,        0, 1);
        // Full-rate mixed mode/scale stream
        send(0, 1, 20, 100, 200, 300, 400, 32767, 0,   200, 300, -100, -100,  0, 1);
        send(1, 1, 21, 100, 200, 300, 400, 16384, 0,   200, 300, -50, -50,    0, 1);
        send(0, 0, 22, -5, 7, 10, -20, 0, 32767,       15, 17, -25, -3,       0, 1);
        send(1, 0, 23, -32768, -32768, -32768, 32767, 32767, 0, -32768, -1, 0, -32768, 1, 1);
        send(0, 1, 24, -32768, 0, 32767, 0, -32768, 0, -32767, 0, 0, 0,       0, 1);
        send(1, 0, 25, 10, 0, 0, 0, -32768, 0,         10, 0, -10, 0,         0, 1);
        drain();

        // Random backpressure with tagged stream
        @(negedge clk);
        bp_mode = 1;
        rdy_chk = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++)
            send(0, 0, i, 100 * i, -i, 1, 0, 32767, 0, 100 * i + 1, -i, 100 * i - 1, -i, 0, 0);
        drain();
        @(negedge clk);
        rdy_chk = 0;
        bp_mode = 2;
        @(posedge clk); #2;

        // Reset with beats in flight
        send(0, 0, 40, 1000, 0, 2000, 0, 32767, 0, 3000, 0, -1000, 0, 0, 0);
        send(0, 0, 41, 1000, 0, 2000, 0, 32767, 0, 3000, 0, -1000, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("pre-reset out_valid", 80'(out_valid), 80'(1));
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("mid-op reset out_valid", 80'(out_valid), 80'(0));
        check("mid-op reset outputs", {y0_re, y0_im, y1_re, y1_im, out_tag, 7'b0, out_ovf}, 80'(0));
        @(negedge clk);
        bp_mode = 0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        send(0, 0, 42, -5, 7, 10, -20, 0, 32767, 15, 17, -25, -3, 0, 1);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
